// File: rtl/cam_stream_sequencer.sv
// cam_stream_sequencer: pops tagged capture-FIFO words into a framed AXI4-Stream video output.
// Optional colour-bar tdata source when TEST_PATTERN_EN is defined.
module cam_stream_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef TEST_PATTERN_EN
  input  logic                             test_pattern_sel,
`endif
  input  logic                             fifo_empty,
  input  logic [DATA_W+1:0]                fifo_dout,
  output logic                             fifo_rd_en,
  output logic [DATA_W-1:0]                m_axis_video_tdata,
  output logic                             m_axis_video_tvalid,
  input  logic                             m_axis_video_tready,
  output logic                             m_axis_video_tuser,
  output logic                             m_axis_video_tlast,
  output logic [$clog2(V_ACTIVE+1)-1:0]    line_count,
  output logic                             frame_done,
  output logic [2:0]                       err_flags
);
  localparam int PW = $clog2(H_ACTIVE+1);
  localparam int LW = $clog2(V_ACTIVE+1);
  typedef enum logic [2:0] {SYNC, VBLANK, LINE, TRAIL, HBLANK} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pix_q, pix_d, idx, pix_nxt;
  logic [LW-1:0] line_q, line_d;
  logic [2:0] err_q, err_d;
  logic [DATA_W-1:0] tdata_q, tdata_d, pixel;
  logic tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d, fd_q, fd_d;
  logic v, h, can_pop, emit, first, last, below;
  assign v       = fifo_dout[DATA_W+1];
  assign h       = fifo_dout[DATA_W];
  assign can_pop = !fifo_empty && (!tvalid_q || m_axis_video_tready);
  assign below   = line_q < LW'(V_ACTIVE);
  assign first   = can_pop && !v && h && state_q == VBLANK;
  assign emit    = can_pop && !v && h &&
                   (state_q == VBLANK || state_q == LINE || (state_q == HBLANK && below));
  assign idx     = (first || state_q == HBLANK) ? '0 : pix_q;
  assign pix_nxt = idx + 1'b1;
  assign last    = pix_nxt == PW'(H_ACTIVE);
`ifdef TEST_PATTERN_EN
  logic [15:0] idx_w;
  logic [DATA_W-1:0] bars;
  assign idx_w = 16'(idx);
  // 32-pixel-wide bars: the bar number idx[9:5] tiled across the word
  always_comb for (int i = 0; i < DATA_W; i++) bars[i] = idx_w[5 + i % 5];
  assign pixel = test_pattern_sel ? bars : fifo_dout[DATA_W-1:0];
`else
  assign pixel = fifo_dout[DATA_W-1:0];
`endif
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (can_pop)
      case (state_q)
        SYNC:   state_d = v ? VBLANK : SYNC;
        VBLANK: state_d = VBLANK;
        LINE: begin
          if (v) begin
            err_d   = err_q | 3'b101;
            state_d = VBLANK;
          end else if (!h) begin
            err_d[0] = 1'b1;
            state_d  = SYNC;
          end
        end
        default: begin
          if (v) begin
            err_d[2] = err_q[2] | below;
            state_d  = VBLANK;
          end else if (!h) state_d = HBLANK;
          else if (state_q == TRAIL) err_d[1] = 1'b1;
          else if (!below) state_d = SYNC;
        end
      endcase
    if (emit) state_d = last ? TRAIL : LINE;
  end
  always_comb begin
    tvalid_d = tvalid_q && !m_axis_video_tready;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    pix_d    = pix_q;
    line_d   = line_q;
    fd_d     = tvalid_q && m_axis_video_tready && tlast_q && line_q == LW'(V_ACTIVE);
    if (emit) begin
      tvalid_d = 1'b1;
      tdata_d  = pixel;
      tuser_d  = first;
      tlast_d  = last;
      pix_d    = pix_nxt;
      line_d   = (first ? '0 : line_q) + LW'(last);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= SYNC;
      pix_q    <= '0;
      line_q   <= '0;
      err_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      fd_q     <= fd_d;
    end
  assign fifo_rd_en          = can_pop && !reset;
  assign m_axis_video_tdata  = tdata_q;
  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tuser  = tuser_q;
  assign m_axis_video_tlast  = tlast_q;
  assign line_count          = line_q;
  assign frame_done          = fd_q;
  assign err_flags           = err_q;
endmodule
